// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller for a simple dual-port RAM of FIFO_DEPTH words.
// Owns the read/write pointers, occupancy, status flags, error strobes and the
// read-valid strobe that lines up with the RAM's registered read data.
module sync_fifo_ctrl #(
    parameter int DATA_WIDTH      = 8,
    parameter int FIFO_DEPTH      = 16,
    parameter int ALMOST_FULL_TH  = 14,
    parameter int ALMOST_EMPTY_TH = 2,
    localparam int ADDR_W         = $clog2(FIFO_DEPTH)
) (
    input  logic                  sys_clk_i,
    input  logic                  sys_rst_n_i,
    input  logic                  clr_i,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    output logic                  full_o,
    output logic                  almost_full_o,
    output logic                  empty_o,
    output logic                  almost_empty_o,
    output logic [ADDR_W:0]       data_count_o,
    output logic                  rd_valid_o,
    output logic                  overflow_o,
    output logic                  underflow_o,
    output logic                  ram_wr_en_o,
    output logic [ADDR_W-1:0]     ram_wr_addr_o,
    output logic [DATA_WIDTH-1:0] ram_wr_data_o,
    output logic [ADDR_W-1:0]     ram_rd_addr_o,
    output logic [ADDR_W-1:0]     ram_rd_pre_addr_o
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] AF_TH_C = CNT_W'(ALMOST_FULL_TH);
    localparam logic [CNT_W-1:0] AE_TH_C = CNT_W'(ALMOST_EMPTY_TH);

    // Pointers carry one extra wrap bit so that their difference spans 0..FIFO_DEPTH.
    logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count, count_d;

    logic full_q, full_d;
    logic almost_full_q, almost_full_d;
    logic empty_q, empty_d;
    logic almost_empty_q, almost_empty_d;
    logic rd_valid_q, rd_valid_d;
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    logic wr_acc;
    logic rd_acc;

    // Acceptance looks only at registered flags: a same-cycle read never makes
    // room for a write, and a same-cycle write never makes data readable.
    assign wr_acc = wr_en_i & ~full_q  & ~clr_i;
    assign rd_acc = rd_en_i & ~empty_q & ~clr_i;

    // Occupancy is the modular pointer distance; the wrap bit resolves full vs empty.
    assign count = wr_ptr_q - rd_ptr_q;

    assign ram_wr_en_o       = wr_acc;
    assign ram_wr_addr_o     = wr_ptr_q[ADDR_W-1:0];
    assign ram_wr_data_o     = wr_data_i;
    assign ram_rd_addr_o     = rd_ptr_q[ADDR_W-1:0];
    assign ram_rd_pre_addr_o = rd_ptr_q[ADDR_W-1:0] + ADDR_W'(1);

    assign full_o         = full_q;
    assign almost_full_o  = almost_full_q;
    assign empty_o        = empty_q;
    assign almost_empty_o = almost_empty_q;
    assign data_count_o   = count;
    assign rd_valid_o     = rd_valid_q;
    assign overflow_o     = overflow_q;
    assign underflow_o    = underflow_q;

    // Next-state: pointer advance, flush, and flags derived from the next occupancy.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count;

        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + CNT_W'(1);
            if (rd_acc) rd_ptr_d = rd_ptr_q + CNT_W'(1);
            count_d = count + CNT_W'(wr_acc) - CNT_W'(rd_acc);
        end

        // With count_d forced to zero on a flush these reduce to the reset values.
        full_d         = (count_d == DEPTH_C);
        empty_d        = (count_d == '0);
        almost_full_d  = (count_d >= AF_TH_C);
        almost_empty_d = (count_d <= AE_TH_C);

        rd_valid_d  = rd_acc;
        overflow_d  = wr_en_i & full_q  & ~clr_i;
        underflow_d = rd_en_i & empty_q & ~clr_i;
    end

    // State registers with asynchronous reset to the empty FIFO.
    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            full_q         <= 1'b0;
            almost_full_q  <= 1'b0;
            empty_q        <= 1'b1;
            almost_empty_q <= 1'b1;
            rd_valid_q     <= 1'b0;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            full_q         <= full_d;
            almost_full_q  <= almost_full_d;
            empty_q        <= empty_d;
            almost_empty_q <= almost_empty_d;
            rd_valid_q     <= rd_valid_d;
            overflow_q     <= overflow_d;
            underflow_q    <= underflow_d;
        end
    end

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed bench for sync_fifo_ctrl with a behavioural simple dual-port RAM
// (registered read) attached to the controller's RAM ports.
module tb_sync_fifo_ctrl;

    localparam int DW = 8;
    localparam int DEPTH = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clr = 1'b0;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_en = 1'b0;
    logic          full, almost_full, empty, almost_empty;
    logic [AW:0]   data_count;
    logic          rd_valid, overflow, underflow;
    logic          ram_wr_en;
    logic [AW-1:0] ram_wr_addr, ram_rd_addr, ram_rd_pre_addr;
    logic [DW-1:0] ram_wr_data;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] ram_rd_data;

    int n_vec = 0;
    int n_err = 0;

    sync_fifo_ctrl #(
        .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .ALMOST_FULL_TH(14), .ALMOST_EMPTY_TH(2)
    ) dut (
        .sys_clk_i(clk), .sys_rst_n_i(rst_n), .clr_i(clr),
        .wr_en_i(wr_en), .wr_data_i(wr_data), .rd_en_i(rd_en),
        .full_o(full), .almost_full_o(almost_full), .empty_o(empty),
        .almost_empty_o(almost_empty), .data_count_o(data_count),
        .rd_valid_o(rd_valid), .overflow_o(overflow), .underflow_o(underflow),
        .ram_wr_en_o(ram_wr_en), .ram_wr_addr_o(ram_wr_addr),
        .ram_wr_data_o(ram_wr_data), .ram_rd_addr_o(ram_rd_addr),
        .ram_rd_pre_addr_o(ram_rd_pre_addr)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: synchronous write, registered read of rd_addr.
    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
        ram_rd_data <= mem[ram_rd_addr];
    end

    // Advance one clock and settle just after the edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            n_vec++;
            if ({empty, almost_empty, full, almost_full} !== 4'b1100) begin
                n_err++;
                $display("FAIL reset_flags cyc%0d: got e/ae/f/af=%b%b%b%b want 1100", i, empty, almost_empty, full, almost_full);
            end
            n_vec++;
            if (data_count !== 5'd0) begin
                n_err++;
                $display("FAIL reset_count cyc%0d: got %0d want 0", i, data_count);
            end
            n_vec++;
            if ({rd_valid, overflow, underflow} !== 3'b000) begin
                n_err++;
                $display("FAIL reset_pulses cyc%0d: got v/o/u=%b%b%b want 000", i, rd_valid, overflow, underflow);
            end
        end
    endtask

    // Write 0x01..0x10 and check occupancy and flags after every write.
    task automatic fill16();
        for (int k = 1; k <= 16; k++) begin
            wr_en = 1'b1;
            wr_data = DW'(k);
            cycle();
            n_vec++;
            if (data_count !== 5'(k)) begin
                n_err++;
                $display("FAIL fill_count w%0d: got %0d want %0d", k, data_count, k);
            end
            n_vec++;
            if ({full, almost_full, empty, almost_empty} !== {k == 16, k >= 14, 1'b0, k <= 2}) begin
                n_err++;
                $display("FAIL fill_flags w%0d: got f/af/e/ae=%b%b%b%b want %b%b0%b", k, full, almost_full, empty, almost_empty, k == 16, k >= 14, k <= 2);
            end
        end
        wr_en = 1'b0;
    endtask

    // Pop n words, expecting data first_val, first_val+1, ...
    task automatic drain(input int n, input logic [DW-1:0] first_val, input string tag);
        int start_cnt;
        start_cnt = int'(data_count);
        for (int i = 0; i < n; i++) begin
            rd_en = 1'b1;
            cycle();
            n_vec++;
            if (rd_valid !== 1'b1 || ram_rd_data !== first_val + DW'(i)) begin
                n_err++;
                $display("FAIL %s_data r%0d: got v=%b d=%h want v=1 d=%h", tag, i, rd_valid, ram_rd_data, first_val + DW'(i));
            end
            n_vec++;
            if (data_count !== 5'(start_cnt - i - 1)) begin
                n_err++;
                $display("FAIL %s_count r%0d: got %0d want %0d", tag, i, data_count, start_cnt - i - 1);
            end
        end
        rd_en = 1'b0;
        cycle();
        n_vec++;
        if (rd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL %s_valid_drop: got %b want 0", tag, rd_valid);
        end
    endtask

    task automatic test_fill_drain();
        fill16();
        for (int i = 1; i <= 16; i++) begin
            rd_en = 1'b1;
            cycle();
            n_vec++;
            if (rd_valid !== 1'b1 || ram_rd_data !== DW'(i)) begin
                n_err++;
                $display("FAIL drain_data r%0d: got v=%b d=%h want v=1 d=%h", i, rd_valid, ram_rd_data, DW'(i));
            end
            n_vec++;
            if ({empty, full} !== {i == 16, 1'b0}) begin
                n_err++;
                $display("FAIL drain_flags r%0d: got e/f=%b%b want %b0", i, empty, full, i == 16);
            end
            if (i == 15) begin
                n_vec++;
                if (ram_rd_addr !== 4'd15 || ram_rd_pre_addr !== 4'd0) begin
                    n_err++;
                    $display("FAIL pre_addr_wrap: got addr=%0d pre=%0d want 15/0", ram_rd_addr, ram_rd_pre_addr);
                end
            end
        end
        rd_en = 1'b0;
        cycle();
    endtask

    task automatic test_full_wr_rd();
        fill16();
        wr_en = 1'b1;
        wr_data = 8'hEE;
        rd_en = 1'b1;
        #1;
        n_vec++;
        if (ram_wr_en !== 1'b0) begin
            n_err++;
            $display("FAIL full_ram_wr_en: got %b want 0", ram_wr_en);
        end
        cycle();
        wr_en = 1'b0;
        rd_en = 1'b0;
        n_vec++;
        if ({overflow, rd_valid, full} !== 3'b110 || ram_rd_data !== 8'h01) begin
            n_err++;
            $display("FAIL full_wr_rd: got o/v/f=%b%b%b d=%h want 110 d=01", overflow, rd_valid, full, ram_rd_data);
        end
        n_vec++;
        if (data_count !== 5'd15) begin
            n_err++;
            $display("FAIL full_wr_rd_count: got %0d want 15", data_count);
        end
        cycle();
        n_vec++;
        if (overflow !== 1'b0) begin
            n_err++;
            $display("FAIL overflow_pulse_len: got %b want 0", overflow);
        end
        drain(15, 8'h02, "post_ovf");
    endtask

    task automatic test_empty_wr_rd();
        wr_en = 1'b1;
        wr_data = 8'hA5;
        rd_en = 1'b1;
        #1;
        n_vec++;
        if (ram_wr_en !== 1'b1 || ram_wr_data !== 8'hA5) begin
            n_err++;
            $display("FAIL empty_ram_wr: got en=%b d=%h want 1/a5", ram_wr_en, ram_wr_data);
        end
        cycle();
        wr_en = 1'b0;
        n_vec++;
        if ({underflow, rd_valid, empty} !== 3'b100 || data_count !== 5'd1) begin
            n_err++;
            $display("FAIL empty_wr_rd: got u/v/e=%b%b%b cnt=%0d want 100 cnt=1", underflow, rd_valid, empty, data_count);
        end
        cycle();
        rd_en = 1'b0;
        n_vec++;
        if ({underflow, rd_valid, empty} !== 3'b011 || ram_rd_data !== 8'hA5) begin
            n_err++;
            $display("FAIL empty_readback: got u/v/e=%b%b%b d=%h want 011 d=a5", underflow, rd_valid, empty, ram_rd_data);
        end
        cycle();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1;
            wr_data = 8'h20 + DW'(i);
            cycle();
        end
        for (int i = 0; i < 40; i++) begin
            wr_en = 1'b1;
            rd_en = 1'b1;
            wr_data = 8'h28 + DW'(i);
            cycle();
            n_vec++;
            if (data_count !== 5'd8 || rd_valid !== 1'b1 || ram_rd_data !== 8'h20 + DW'(i)) begin
                n_err++;
                $display("FAIL steady c%0d: got cnt=%0d v=%b d=%h want cnt=8 v=1 d=%h", i, data_count, rd_valid, ram_rd_data, 8'h20 + DW'(i));
            end
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        drain(8, 8'h48, "steady_tail");
    endtask

    task automatic test_clear();
        for (int i = 0; i < 10; i++) begin
            wr_en = 1'b1;
            wr_data = 8'h60 + DW'(i);
            cycle();
        end
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        wr_en = 1'b0;
        n_vec++;
        if (data_count !== 5'd0 || {empty, almost_empty, full, almost_full} !== 4'b1100) begin
            n_err++;
            $display("FAIL clear10: got cnt=%0d e/ae/f/af=%b%b%b%b want cnt=0 1100", data_count, empty, almost_empty, full, almost_full);
        end
        n_vec++;
        if ({overflow, underflow, rd_valid} !== 3'b000 || ram_wr_addr !== 4'd0 || ram_rd_addr !== 4'd0) begin
            n_err++;
            $display("FAIL clear10_misc: got o/u/v=%b%b%b wa=%0d ra=%0d want 000 0 0", overflow, underflow, rd_valid, ram_wr_addr, ram_rd_addr);
        end
        // Flush while full with both requests: nothing accepted, nothing flagged.
        fill16();
        clr = 1'b1;
        wr_en = 1'b1;
        rd_en = 1'b1;
        cycle();
        n_vec++;
        if ({overflow, underflow, rd_valid, empty} !== 4'b0001 || data_count !== 5'd0) begin
            n_err++;
            $display("FAIL clear_full: got o/u/v/e=%b%b%b%b cnt=%0d want 0001 cnt=0", overflow, underflow, rd_valid, empty, data_count);
        end
        // Flush while empty with a read: no underflow.
        cycle();
        clr = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        n_vec++;
        if ({overflow, underflow, rd_valid} !== 3'b000) begin
            n_err++;
            $display("FAIL clear_empty: got o/u/v=%b%b%b want 000", overflow, underflow, rd_valid);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1;
            wr_data = 8'h70 + DW'(i);
            rd_en = (i == 2);
            cycle();
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (data_count !== 5'd0 || {empty, almost_empty, full, almost_full} !== 4'b1100 || rd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: got cnt=%0d e/ae/f/af=%b%b%b%b v=%b want cnt=0 1100 v=0", data_count, empty, almost_empty, full, almost_full, rd_valid);
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        cycle();
        rst_n = 1'b1;
        cycle();
        n_vec++;
        if (ram_wr_addr !== 4'd0 || ram_rd_addr !== 4'd0 || empty !== 1'b1) begin
            n_err++;
            $display("FAIL post_reset_ptrs: got wa=%0d ra=%0d e=%b want 0 0 1", ram_wr_addr, ram_rd_addr, empty);
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_full_wr_rd();
        test_empty_wr_rd();
        test_back_to_back();
        test_clear();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
